// File: rtl/ili9341_spi_tx_if.sv
// Handshake between the command sequencer and the ILI9341 SPI byte transmitter.
// The sequencer drives the master side; the transmitter responds on the slave side.
interface ili9341_spi_tx_if #(
    parameter int DW = 8
);
    logic          i_send;
    logic [DW-1:0] i_data;
    logic          i_dc;
    logic          i_cs;
    logic          o_command_sent;
    logic          o_busy;

    modport master (
        output i_send, i_data, i_dc, i_cs,
        input  o_command_sent, o_busy
    );

    modport slave (
        input  i_send, i_data, i_dc, i_cs,
        output o_command_sent, o_busy
    );
endinterface

// File: rtl/ili9341_spi_tx.sv
// SPI mode-0 word transmitter for the ILI9341 panel: latches a word with its D/C and CS
// attributes, shifts it out MSB-first, then pulses command_sent for one cycle.
module ili9341_spi_tx #(
    parameter int DW      = 8,
    parameter int CLK_DIV = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    ili9341_spi_tx_if.slave       host,
    output logic                  o_sclk,
    output logic                  o_mosi,
    output logic                  o_dc,
    output logic                  o_cs
);
    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int BIT_W = $clog2(DW);
    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DW - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SCLK_HI,
        SCLK_LO,
        HOLD,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DW-1:0]     shreg_q, shreg_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic              dc_q, dc_d;
    logic              cs_q, cs_d;
    logic              sent_q, sent_d;
    logic              busy_q, busy_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            dc_q    <= 1'b1;
            cs_q    <= 1'b1;
            sent_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            dc_q    <= dc_d;
            cs_q    <= cs_d;
            sent_q  <= sent_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        div_d   = (div_q != '0) ? div_q - 1'b1 : div_q;
        dc_d    = dc_q;
        cs_d    = cs_q;
        mosi_d  = mosi_q;

        case (state_q)
            IDLE: begin
                if (host.i_send) begin
                    shreg_d = host.i_data;
                    bit_d   = BIT_LAST;
                    dc_d    = host.i_dc;
                    cs_d    = host.i_cs;
                    state_d = SETUP;
                end
            end
            SETUP:   if (div_q == '0) state_d = SCLK_HI;
            SCLK_HI: begin
                if (div_q == '0) begin
                    if (bit_q == '0) begin
                        state_d = HOLD;
                    end else begin
                        bit_d   = bit_q - 1'b1;
                        shreg_d = {shreg_q[DW-2:0], 1'b0};
                        state_d = SCLK_LO;
                    end
                end
            end
            SCLK_LO: if (div_q == '0) state_d = SCLK_HI;
            HOLD:    if (div_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) div_d = DIV_RELOAD;

        // Outputs are decoded from the state being entered so the pins change on the same edge.
        sclk_d = (state_d == SCLK_HI);
        sent_d = (state_d == DONE);
        busy_d = (state_d != IDLE);
        case (state_d)
            IDLE: begin
                cs_d   = 1'b1;
                mosi_d = 1'b0;
            end
            SETUP, SCLK_HI, SCLK_LO: mosi_d = shreg_d[DW-1];
            DONE:    cs_d = 1'b1;
            default: ;
        endcase
    end

    assign o_sclk              = sclk_q;
    assign o_mosi              = mosi_q;
    assign o_dc                = dc_q;
    assign o_cs                = cs_q;
    assign host.o_command_sent = sent_q;
    assign host.o_busy         = busy_q;
endmodule

// File: tb/tb_ili9341_spi_tx.sv
// Drives two transmitters (CLK_DIV=2 and CLK_DIV=1) with identical stimulus and checks
// every pin each cycle against a phase-arithmetic model of the SPI waveform.
module tb_ili9341_spi_tx;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          send_r = 1'b0;
    logic [DW-1:0] data_r = '0;
    logic          dc_r   = 1'b0;
    logic          cs_r   = 1'b0;

    logic sclk_w [2];
    logic mosi_w [2];
    logic dc_w   [2];
    logic cs_w   [2];
    logic sent_w [2];
    logic busy_w [2];

    ili9341_spi_tx_if #(.DW(DW)) ifa ();
    ili9341_spi_tx_if #(.DW(DW)) ifb ();

    assign ifa.i_send = send_r;
    assign ifa.i_data = data_r;
    assign ifa.i_dc   = dc_r;
    assign ifa.i_cs   = cs_r;
    assign ifb.i_send = send_r;
    assign ifb.i_data = data_r;
    assign ifb.i_dc   = dc_r;
    assign ifb.i_cs   = cs_r;
    assign sent_w[0]  = ifa.o_command_sent;
    assign busy_w[0]  = ifa.o_busy;
    assign sent_w[1]  = ifb.o_command_sent;
    assign busy_w[1]  = ifb.o_busy;

    ili9341_spi_tx #(.DW(DW), .CLK_DIV(2)) dut_a (
        .clk(clk), .rst(rst), .host(ifa.slave),
        .o_sclk(sclk_w[0]), .o_mosi(mosi_w[0]), .o_dc(dc_w[0]), .o_cs(cs_w[0])
    );

    ili9341_spi_tx #(.DW(DW), .CLK_DIV(1)) dut_b (
        .clk(clk), .rst(rst), .host(ifb.slave),
        .o_sclk(sclk_w[1]), .o_mosi(mosi_w[1]), .o_dc(dc_w[1]), .o_cs(cs_w[1])
    );

    int n_checks = 0;
    int n_errors = 0;

    function automatic int clk_div_of(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    task automatic chk(input string name, input int d, input int k,
                       input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s dut%0d k=%0d: got %0h expected %0h", name, d, k, act, exp);
        end
    endtask

    // Model: T=(2*DW+1)*CLK_DIV cycles of activity; phase p=k/CLK_DIV selects
    // setup (0), SCLK high (odd), SCLK low (even), hold (2*DW), and done at k=T.
    task automatic check_cycle(input int d, input int k, input logic [DW-1:0] data,
                               input logic dc, input logic cs);
        int   cd;
        int   t;
        int   p;
        logic e_sclk;
        logic e_mosi;
        cd = clk_div_of(d);
        t  = (2*DW + 1) * cd;
        p  = k / cd;
        e_sclk = (k < t) && (p >= 1) && (p <= 2*DW - 1) && (p % 2 == 1);
        if (k > t)           e_mosi = 1'b0;
        else if (p >= 2*DW)  e_mosi = data[0];
        else                 e_mosi = data[DW-1-p/2];
        chk("busy", d, k, 32'(busy_w[d]), 32'(k <= t));
        chk("sent", d, k, 32'(sent_w[d]), 32'(k == t));
        chk("cs",   d, k, 32'(cs_w[d]),   32'((k < t) ? cs : 1'b1));
        chk("dc",   d, k, 32'(dc_w[d]),   32'(dc));
        chk("sclk", d, k, 32'(sclk_w[d]), 32'(e_sclk));
        chk("mosi", d, k, 32'(mosi_w[d]), 32'(e_mosi));
    endtask

    task automatic run_xfer(input logic [DW-1:0] data, input logic dc, input logic cs,
                            input logic disturb);
        logic [DW-1:0] stream [2];
        int            edges  [2];
        logic          prev   [2];
        @(negedge clk);
        send_r = 1'b1;
        data_r = data;
        dc_r   = dc;
        cs_r   = cs;
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            stream[d] = '0;
            edges[d]  = 0;
            prev[d]   = 1'b0;
        end
        for (int k = 0; k <= 36; k++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                check_cycle(d, k, data, dc, cs);
                if (sclk_w[d] && !prev[d]) begin
                    stream[d] = {stream[d][DW-2:0], mosi_w[d]};
                    edges[d]++;
                end
                prev[d] = sclk_w[d];
            end
            if (k == 0) send_r = 1'b0;
            if (disturb && k == 5) begin
                data_r = ~data;
                dc_r   = ~dc;
                cs_r   = ~cs;
                send_r = 1'b1;
            end
            if (disturb && k == 6) send_r = 1'b0;
        end
        for (int d = 0; d < 2; d++) begin
            chk("sclk_edges", d, 0, 32'(edges[d]), 32'(DW));
            chk("stream", d, 0, 32'(stream[d]), 32'(data));
        end
    endtask

    typedef struct {
        logic [DW-1:0] data;
        logic          dc;
        logic          cs;
        logic          disturb;
        logic [DW-1:0] exp_stream;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int sent_k [2][$];
        int exp_k;

        vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 8'hA5};
        vecs[1] = '{8'h2A, 1'b0, 1'b0, 1'b0, 8'h2A};
        vecs[2] = '{8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF};
        vecs[3] = '{8'h81, 1'b0, 1'b0, 1'b0, 8'h81};
        vecs[4] = '{8'h3C, 1'b1, 1'b1, 1'b0, 8'h3C};
        vecs[5] = '{8'h00, 1'b0, 1'b1, 1'b1, 8'h00};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk("rst_cs",   d, 0, 32'(cs_w[d]),   32'd1);
            chk("rst_dc",   d, 0, 32'(dc_w[d]),   32'd1);
            chk("rst_sclk", d, 0, 32'(sclk_w[d]), 32'd0);
            chk("rst_mosi", d, 0, 32'(mosi_w[d]), 32'd0);
            chk("rst_busy", d, 0, 32'(busy_w[d]), 32'd0);
            chk("rst_sent", d, 0, 32'(sent_w[d]), 32'd0);
        end

        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            run_xfer(v.data, v.dc, v.cs, v.disturb);
            chk("vec_stream_ref", i, 0, 32'(v.data), 32'(v.exp_stream));
        end

        for (int n = 0; n < 20; n++) begin
            run_xfer(DW'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end

        // Request held high: both transmitters re-accept every T+2 cycles.
        @(negedge clk);
        send_r = 1'b1;
        data_r = 8'h2A;
        dc_r   = 1'b0;
        cs_r   = 1'b0;
        @(posedge clk);
        for (int k = 0; k <= 80; k++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (sent_w[d]) sent_k[d].push_back(k);
            end
            chk("held_dc", 0, k, 32'(dc_w[0]), 32'd0);
            if (k == 39) send_r = 1'b0;
        end
        for (int d = 0; d < 2; d++) begin
            int t;
            int idx;
            t   = (2*DW + 1) * clk_div_of(d);
            idx = 0;
            for (int a = 0; a < 40; a += t + 2) begin
                exp_k = (idx < sent_k[d].size()) ? sent_k[d][idx] : -1;
                chk("held_sent_at", d, idx, 32'(exp_k), 32'(a + t));
                idx++;
            end
            chk("held_pulses", d, 0, 32'(sent_k[d].size()), 32'(idx));
        end

        // Reset ten edges into a transfer aborts it silently.
        @(negedge clk);
        send_r = 1'b1;
        data_r = 8'h5A;
        dc_r   = 1'b0;
        cs_r   = 1'b0;
        @(posedge clk);
        for (int k = 0; k <= 9; k++) begin
            @(negedge clk);
            if (k == 0) send_r = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk("abort_cs",   d, 0, 32'(cs_w[d]),   32'd1);
            chk("abort_sclk", d, 0, 32'(sclk_w[d]), 32'd0);
            chk("abort_mosi", d, 0, 32'(mosi_w[d]), 32'd0);
            chk("abort_dc",   d, 0, 32'(dc_w[d]),   32'd1);
            chk("abort_busy", d, 0, 32'(busy_w[d]), 32'd0);
        end
        begin
            int pulses [2];
            pulses[0] = 0;
            pulses[1] = 0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                for (int d = 0; d < 2; d++) if (sent_w[d]) pulses[d]++;
            end
            for (int d = 0; d < 2; d++) chk("abort_no_sent", d, 0, 32'(pulses[d]), 32'd0);
        end
        run_xfer(8'hC3, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
